// File: rtl/k_type.sv
// Majority-vote classifier: histograms the K nearest neighbour types and
// reports the most frequent one, ties resolved toward the nearest neighbour.
module k_type #(
    parameter int unsigned K      = 5,
    parameter int unsigned TYPE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_sort,
    input  logic [K*TYPE_W-1:0]   k_nearest_neighbours_type,
    output logic [TYPE_W-1:0]     inferred_type,
    output logic                  inference_done
);

    localparam int unsigned NTYPES = 2**TYPE_W;
    localparam int unsigned CNT_W  = $clog2(K + 1);
    localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_SELECT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [K-1:0][TYPE_W-1:0]   r_types;
    logic [CNT_W-1:0]           r_hist [NTYPES];
    logic [IDX_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_best_cnt;
    logic [TYPE_W-1:0]          r_best_type;
    logic [TYPE_W-1:0]          r_inferred;
    logic                       r_done;

    logic                       w_last;
    logic [TYPE_W-1:0]          w_cur_type;
    logic [CNT_W-1:0]           w_cur_cnt;
    logic                       w_better;
    logic                       w_capture;
    logic                       w_count;
    logic                       w_select;

    assign w_last     = (r_idx == IDX_W'(K - 1));
    assign w_cur_type = r_types[r_idx];
    assign w_cur_cnt  = r_hist[w_cur_type];
    assign w_better   = (w_cur_cnt > r_best_cnt);

    assign inferred_type  = r_inferred;
    assign inference_done = r_done;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (valid_sort) w_state_nxt = S_COUNT;
            S_COUNT:  if (w_last)     w_state_nxt = S_SELECT;
            S_SELECT: if (w_last)     w_state_nxt = S_DONE;
            S_DONE:                   w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath control decode
    always_comb begin
        w_capture = 1'b0;
        w_count   = 1'b0;
        w_select  = 1'b0;
        case (r_state)
            S_IDLE:   w_capture = valid_sort;
            S_COUNT:  w_count   = 1'b1;
            S_SELECT: w_select  = 1'b1;
            default:  ;
        endcase
    end

    // Histogram, index and best-candidate tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_types     <= '0;
            r_idx       <= '0;
            r_best_cnt  <= '0;
            r_best_type <= '0;
            r_inferred  <= '0;
            r_done      <= 1'b0;
            for (int unsigned i = 0; i < NTYPES; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_types <= k_nearest_neighbours_type;
                r_idx   <= '0;
                for (int unsigned i = 0; i < NTYPES; i++) begin
                    r_hist[i] <= '0;
                end
            end
            if (w_count) begin
                r_hist[w_cur_type] <= w_cur_cnt + CNT_W'(1);
                if (w_last) begin
                    r_idx       <= '0;
                    r_best_cnt  <= '0;
                    r_best_type <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            // Strict compare keeps the earliest index on ties
            if (w_select) begin
                if (w_better) begin
                    r_best_cnt  <= w_cur_cnt;
                    r_best_type <= w_cur_type;
                end
                if (w_last) begin
                    r_idx      <= '0;
                    r_inferred <= w_better ? w_cur_type : r_best_type;
                    r_done     <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_k_type.sv
// Bench for k_type: directed and random votes against a counting reference.
module tb_k_type;

    localparam int unsigned K      = 5;
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned BUS_W  = K * TYPE_W;

    logic               clk;
    logic               rst;
    logic               valid_sort;
    logic [BUS_W-1:0]   bus;
    logic [TYPE_W-1:0]  inferred_type;
    logic               inference_done;

    int checks   = 0;
    int failures = 0;

    k_type #(.K(K), .TYPE_W(TYPE_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .valid_sort                (valid_sort),
        .k_nearest_neighbours_type (bus),
        .inferred_type             (inferred_type),
        .inference_done            (inference_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count occurrences of each entry's type; first entry with the highest count wins
    function automatic logic [TYPE_W-1:0] model(input logic [BUS_W-1:0] v);
        int best_i = 0;
        int best_c = 0;
        for (int i = 0; i < int'(K); i++) begin
            int c = 0;
            for (int j = 0; j < int'(K); j++) begin
                if (v[j*TYPE_W +: TYPE_W] == v[i*TYPE_W +: TYPE_W]) c++;
            end
            if (c > best_c) begin
                best_c = c;
                best_i = i;
            end
        end
        return v[best_i*TYPE_W +: TYPE_W];
    endfunction

    function automatic logic [BUS_W-1:0] pack5(input int a, input int b, input int c,
                                                input int d, input int e);
        return {TYPE_W'(e), TYPE_W'(d), TYPE_W'(c), TYPE_W'(b), TYPE_W'(a)};
    endfunction

    // Called at a negedge; capture happens at the following posedge
    task automatic start(input logic [BUS_W-1:0] v);
        bus        = v;
        valid_sort = 1'b1;
        @(negedge clk);
        valid_sort = 1'b0;
    endtask

    // Waits for the done pulse, checking latency, result, hold and pulse width.
    // Returns positioned at the negedge after the done cycle.
    task automatic finish_vote(input string tag, input logic [TYPE_W-1:0] exp,
                               input bit disturb);
        int lat = 0;
        logic [TYPE_W-1:0] prev;
        prev = inferred_type;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (inference_done) break;
            if (inferred_type !== prev) check({tag, "_hold"}, 32'(inferred_type), 32'(prev));
            if (disturb && lat == 3) begin
                bus        = pack5(7, 7, 7, 7, 7);
                valid_sort = 1'b1;
            end else begin
                valid_sort = 1'b0;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check({tag, "_type"}, 32'(inferred_type), 32'(exp));
        @(negedge clk);
        check({tag, "_pulse_width"}, 32'(inference_done), 32'd0);
    endtask

    task automatic no_done_for(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (inference_done) seen++;
        end
        check({tag, "_no_extra_done"}, 32'(seen), 32'd0);
    endtask

    logic [BUS_W-1:0] v;

    initial begin
        rst        = 1'b0;
        valid_sort = 1'b0;
        bus        = '0;
        #3;
        check("reset_type", 32'(inferred_type), 32'd0);
        check("reset_done", 32'(inference_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All identical
        start(pack5(3, 3, 3, 3, 3));
        finish_vote("t1_all3", 4'd3, 1'b0);

        // Tie 2 vs 7: earlier index wins
        start(pack5(1, 2, 2, 7, 7));
        finish_vote("t2_tie", 4'd2, 1'b0);

        // All distinct: nearest neighbour wins
        start(pack5(9, 4, 6, 0, 10));
        finish_vote("t3_distinct", 4'd9, 1'b0);

        // Bus change and valid_sort pulse while busy must be ignored
        start(pack5(5, 0, 5, 0, 5));
        finish_vote("t4_busy", 4'd5, 1'b0 | 1'b1);
        no_done_for("t4", 14);

        // Back-to-back votes, histogram must not carry over
        start(pack5(8, 8, 1, 1, 1));
        finish_vote("t5a", 4'd1, 1'b0);
        start(pack5(8, 2, 2, 8, 3));
        finish_vote("t5b", 4'd8, 1'b0);
        start(pack5(4, 6, 6, 4, 1));
        finish_vote("t5c", 4'd4, 1'b0);

        // Reset during COUNT aborts the vote
        start(pack5(12, 12, 12, 0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_type", 32'(inferred_type), 32'd0);
        check("t6_rst_done", 32'(inference_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        no_done_for("t6", 15);
        start(pack5(11, 13, 13, 11, 13));
        finish_vote("t6_after", 4'd13, 1'b0);

        // Random votes, half drawn from a small alphabet to provoke ties
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < int'(K); i++) begin
                v[i*TYPE_W +: TYPE_W] = (n % 2 == 0) ? TYPE_W'($urandom_range(0, 3))
                                                     : TYPE_W'($urandom);
            end
            start(v);
            finish_vote($sformatf("rand%0d", n), model(v), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
